hazard_unit_mc: RTL

- Next-generation hazard and forwarding unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Adds the following over the fixed-width single-cycle unit:
  - parametrised register-address width;
  - multi-cycle data-memory wait handling via a ready handshake;
  - a multiply/divide (MDU) busy countdown that stalls mfhi/mflo;
  - a memory-wait watchdog;
  - a saturating stall-cycle performance counter.
- Sits beside the datapath. Drives the stall, flush and forward selects of every pipeline register.

---
 rtl/hazard_unit_mc_if.sv | 54 +++++
 rtl/hazard_unit_mc.sv | 136 +++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc_if.sv
// Hazard unit bus: pipeline-side hazard inputs and the stall/flush/forward controls returned to the datapath.
interface hazard_unit_mc_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);
  logic             BranchD;
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RsE;
  logic [REG_W-1:0] RtE;
  logic             RegWriteE;
  logic             MemToRegE;
  logic [REG_W-1:0] WriteRegE;
  logic             RegWriteM;
  logic             MemToRegM;
  logic [REG_W-1:0] WriteRegM;
  logic             RegWriteW;
  logic [REG_W-1:0] WriteRegW;
  logic             MemAccessM;
  logic             MemReadyM;
  logic             MduStartE;
  logic             MduReadD;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushE;
  logic             FlushW;
  logic             ForwardAD;
  logic             ForwardBD;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MduBusy;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output BranchD, RsD, RtD, RsE, RtE, RegWriteE, MemToRegE, WriteRegE,
           RegWriteM, MemToRegM, WriteRegM, RegWriteW, WriteRegW,
           MemAccessM, MemReadyM, MduStartE, MduReadD,
    input  StallF, StallD, StallE, StallM, FlushE, FlushW,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MduBusy, MemTimeout, StallCycles
  );

  modport slave (
    input  BranchD, RsD, RtD, RsE, RtE, RegWriteE, MemToRegE, WriteRegE,
           RegWriteM, MemToRegM, WriteRegM, RegWriteW, WriteRegW,
           MemAccessM, MemReadyM, MduStartE, MduReadD,
    output StallF, StallD, StallE, StallM, FlushE, FlushW,
           ForwardAD, ForwardBD, ForwardAE, ForwardBE,
           MduBusy, MemTimeout, StallCycles
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard/forwarding unit for the 5-stage pipeline with memory-wait, MDU busy,
// watchdog and stall-cycle counting.
module hazard_unit_mc #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MDU_LAT     = 4,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_mc_if.slave  hz
);

  localparam int unsigned MDU_W = $clog2(MDU_LAT + 1);
  localparam int unsigned WD_W  = $clog2(MEM_TIMEOUT + 1);

  logic [MDU_W-1:0] r_mdu_cnt;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_lwstall;
  logic       w_branchstall;
  logic       w_mdustall;
  logic       w_memstall;
  logic       w_dstall;
  logic       w_mdu_busy;
  logic       w_stall_f;
  logic       w_stall_d;
  logic       w_stall_e;
  logic       w_stall_m;
  logic       w_flush_e;
  logic       w_flush_w;
  logic [1:0] w_fwd_ae;
  logic [1:0] w_fwd_be;

  // Register-match helper: $0 is hard-wired and never a real dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign w_mdu_busy = (r_mdu_cnt != '0);

  // Forward selects: M result takes priority over W result.
  always_comb begin
    w_fwd_ae = 2'b00;
    w_fwd_be = 2'b00;
    if (hz.RegWriteM && reg_match(hz.RsE, hz.WriteRegM))      w_fwd_ae = 2'b10;
    else if (hz.RegWriteW && reg_match(hz.RsE, hz.WriteRegW)) w_fwd_ae = 2'b01;
    if (hz.RegWriteM && reg_match(hz.RtE, hz.WriteRegM))      w_fwd_be = 2'b10;
    else if (hz.RegWriteW && reg_match(hz.RtE, hz.WriteRegW)) w_fwd_be = 2'b01;
  end

  always_comb begin
    w_lwstall     = hz.MemToRegE &&
                    (reg_match(hz.RtE, hz.RsD) || reg_match(hz.RtE, hz.RtD));
    w_branchstall = hz.BranchD &&
                    ((hz.RegWriteE &&
                      (reg_match(hz.WriteRegE, hz.RsD) || reg_match(hz.WriteRegE, hz.RtD))) ||
                     (hz.MemToRegM &&
                      (reg_match(hz.WriteRegM, hz.RsD) || reg_match(hz.WriteRegM, hz.RtD))));
    w_mdustall    = hz.MduReadD && (w_mdu_busy || hz.MduStartE);
    w_memstall    = hz.MemAccessM && !hz.MemReadyM;
    w_dstall      = w_lwstall || w_branchstall || w_mdustall;
  end

  // Memory wait freezes the whole front and bubbles W; D-stage hazards wait behind it.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_e = 1'b0;
    w_flush_w = 1'b0;
    if (!reset) begin
      if (w_memstall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
        w_flush_w = 1'b1;
      end else if (w_dstall) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  // MDU occupancy countdown; a held E stage does not launch the operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mdu_cnt <= '0;
    end else if (hz.MduStartE && !w_stall_e) begin
      r_mdu_cnt <= MDU_W'(MDU_LAT);
    end else if (r_mdu_cnt != '0) begin
      r_mdu_cnt <= r_mdu_cnt - MDU_W'(1);
    end
  end

  // Watchdog counts consecutive wait cycles; the timeout flag is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (w_memstall) begin
      if (r_wd_cnt != WD_W'(MEM_TIMEOUT)) r_wd_cnt <= r_wd_cnt + WD_W'(1);
      if (r_wd_cnt == WD_W'(MEM_TIMEOUT - 1)) r_timeout <= 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign hz.StallF      = w_stall_f;
  assign hz.StallD      = w_stall_d;
  assign hz.StallE      = w_stall_e;
  assign hz.StallM      = w_stall_m;
  assign hz.FlushE      = w_flush_e;
  assign hz.FlushW      = w_flush_w;
  assign hz.ForwardAD   = hz.RegWriteM && reg_match(hz.RsD, hz.WriteRegM);
  assign hz.ForwardBD   = hz.RegWriteM && reg_match(hz.RtD, hz.WriteRegM);
  assign hz.ForwardAE   = w_fwd_ae;
  assign hz.ForwardBE   = w_fwd_be;
  assign hz.MduBusy     = w_mdu_busy;
  assign hz.MemTimeout  = r_timeout;
  assign hz.StallCycles = r_stall_cnt;

endmodule
